// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and types for the 4:1 mux select scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int SEL_W = 2;
  localparam int N_CH  = 4;

  localparam logic [N_CH-1:0] ANODE_OFF = '1;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Free-running 0..PRESCALE-1 counter with freeze, clear and a
//            combinational terminal-count strobe for the wrapping edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int              CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  // en gates everything so a frozen scan keeps its position, even under clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      if (clr || (r_cnt == c_last)) r_cnt <= '0;
      else                          r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tc = en & ~clr & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/mux_select_scanner.sv
// ============================================================================
// Module   : mux_select_scanner
// Purpose  : Rotates a mux select at a programmable rate and drives a blanked,
//            active-low one-hot anode bus for a multiplexed 7-segment display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_select_scanner #(
  parameter int PRESCALE  = 50000,
  parameter int N_CH      = 4,
  parameter int SEL_W     = 2,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic [SEL_W-1:0] hold_sel,
  output logic [SEL_W-1:0] select,
  output logic [N_CH-1:0]  anode,
  output logic             tick,
  output logic             blank
);

  import mux_pkg::*;

  localparam int               BW        = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [BW-1:0]    c_bload   = BW'(BLANK_CYC);
  localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] r_sel;
  logic [BW-1:0]    r_bcnt;
  logic             r_tick;
  logic [N_CH-1:0]  r_anode;
  logic             r_blank;

  logic             w_tc;
  logic [SEL_W-1:0] w_hold_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_change;
  logic [BW-1:0]    w_bcnt_nxt;
  logic             w_dark;
  logic [N_CH-1:0]  w_anode_lit;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (hold),
    .tc    (w_tc)
  );

  assign w_hold_sel = (hold_sel > c_last_ch) ? c_last_ch : hold_sel;

  // Priority: en=0 freezes, then hold, then terminal count
  always_comb begin
    w_sel_nxt = r_sel;
    if (en) begin
      if (hold)      w_sel_nxt = w_hold_sel;
      else if (w_tc) w_sel_nxt = (r_sel == c_last_ch) ? '0 : r_sel + SEL_W'(1);
    end
  end

  assign w_change = (w_sel_nxt != r_sel);

  always_comb begin
    w_bcnt_nxt = r_bcnt;
    if (w_change)                      w_bcnt_nxt = c_bload;
    else if (en && (r_bcnt != '0))     w_bcnt_nxt = r_bcnt - BW'(1);
  end

  // Outputs are decoded from next-state so they line up with the new select
  assign w_dark      = ~en | (w_bcnt_nxt != '0);
  assign w_anode_lit = ~(N_CH'(1) << w_sel_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_bcnt  <= '0;
      r_tick  <= 1'b0;
      r_anode <= '1;
      r_blank <= 1'b1;
    end else begin
      r_sel   <= w_sel_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_tick  <= w_change;
      r_anode <= w_dark ? '1 : w_anode_lit;
      r_blank <= w_dark;
    end
  end

  assign select = r_sel;
  assign anode  = r_anode;
  assign tick   = r_tick;
  assign blank  = r_blank;

endmodule

`default_nettype wire

// File: doc/mux_select_scanner.md
Name: mux_select_scanner

Overview:
- Upstream sequencer for the 4:1 parametric mux (4-bit channels, 2-bit select).
- Rotates the mux select through all channels at a programmable rate.
- Drives a matching active-low one-hot anode bus for time-multiplexed 7-segment display.
- Supports a hold mode (fixed channel) and a short anode blanking window after each channel change to suppress ghosting.

Parameters:
- PRESCALE, 50000: clk cycles spent on each channel (must be ≥2).
- N_CH, 4: number of channels scanned; select wraps N_CH-1 -> 0.
- SEL_W, 2: select width, ≥ clog2(N_CH).
- BLANK_CYC, 2: cycles anode is forced off after a select change (0 = no blanking; must be < PRESCALE).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- hold  in  1  1 = force select to hold_sel, no rotation.
- hold_sel  in  SEL_W  channel used while hold=1 (values ≥N_CH are clamped to N_CH-1).
- select  out  SEL_W  registered mux select; connects to mux select.
- anode  out  N_CH  registered active-low one-hot; bit[select]=0 when lit.
- tick  out  1  one-cycle pulse, high in the cycle after select changes value.
- blank  out  1  high while anode is forced all-ones.

Behaviour:
- Reset (async assert, sync deassert at the next edge after rst_n rises):
  - select=0, prescale count=0, blank count=0.
  - anode=all ones, tick=0, blank=1.
- All outputs are registered; no combinational path from input to output.
- en=0:
  - Prescale count and select are frozen.
  - anode=all ones, blank=1, tick=0.
  - Re-enabling resumes from the frozen count, with no restart.
- en=1, hold=0:
  - Prescale count increments each cycle 0..PRESCALE-1.
  - At count=PRESCALE-1 the count wraps to 0 and, on the same edge, select <= (select==N_CH-1) ? 0 : select+1.
  - Dwell per channel is exactly PRESCALE cycles.
- en=1, hold=1:
  - On the next edge, select <= clamped hold_sel and prescale count <= 0.
  - The count stays at 0 while hold=1.
  - On hold falling, rotation resumes from the held channel with a full PRESCALE dwell.
- tick:
  - Registered compare of the new vs. old select; high for exactly 1 cycle per actual value change.
  - A hold_sel equal to the current select produces no tick.
- Blanking:
  - On any edge where select changes, blank count <= BLANK_CYC.
  - While blank count>0: anode=all ones, blank=1, count decrements.
  - Otherwise anode=~(1<<select), blank=0.
  - With BLANK_CYC=0, anode follows select on the same edge.
  - A new change during blanking reloads the count.
- Wrap-around: select never presents a value ≥N_CH.
- Simultaneous events:
  - hold has priority over terminal count.
  - en=0 has priority over hold.
  - Reset overrides all.
- Reset mid-scan: outputs go to reset values immediately (asynchronous); the next scan starts at channel 0 with a full dwell.

Decomposition:
- Shared package mux_pkg:
  - SEL_W, N_CH constants.
  - ANODE_OFF (all-ones) constant.
  - Channel index typedef sel_t, logic [SEL_W-1:0].
- One sub-module, tick_prescaler (PRESCALE parameter):
  - Inputs: clk, rst_n, en, clr.
  - Output: terminal-count pulse.
  - Used by the scanner to advance select.
- Everything else (select register, blank counter, anode decode) stays in mux_select_scanner.

Test Plan:
- Bench parameters: PRESCALE=4, BLANK_CYC=1, N_CH=4.
- Reset: assert rst_n=0 mid-cycle -> select=0, anode=4'b1111, tick=0, blank=1 immediately, without waiting for clk.
- Free scan, en=1 hold=0 for 20 cycles:
  - select sequence 0,1,2,3,0 changes every 4 cycles.
  - tick high one cycle per change.
  - anode=1111 for 1 cycle after each change, then 1110, 1101, 1011, 0111 in turn.
- Freeze: drop en for 5 cycles at count 2 on channel 1 -> anode=1111, select stays 1; after re-enable, select->2 after exactly 2 more cycles.
- Hold:
  - hold=1, hold_sel=3 while on channel 0 -> next edge select=3, tick pulse, anode 0111 after blank; stays for 10 cycles.
  - Release hold -> select=0 after exactly 4 cycles.
- Hold same channel and clamp:
  - hold_sel equal to current select -> no tick, no blank.
  - With N_CH=3 and SEL_W=2: hold_sel=3 -> select=2.
  - Free scan with N_CH=3 wraps 2->0.
- Priority: en=0 and hold=1 together -> select unchanged, anode=1111; asserting en -> hold applied on the next edge.
